// File: rtl/dm_port_arbiter_if.sv
// Requester-side bundle for one data-memory port of dm_port_arbiter.
// master = requester (core or AHB/debug side), slave = the arbiter.
interface dm_port_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic                  req;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wstrb;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, write, addr, wdata, wstrb, input gnt, rvalid, rdata);
    modport slave  (input req, write, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter for the single-port DM; partial writes become read-modify-write.
// Define DM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module dm_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    dm_port_arbiter_if.slave      p0,
    dm_port_arbiter_if.slave      p1,
    output logic                  busy,
    output logic                  DM_enable,
    output logic                  DM_write,
    output logic [ADDR_WIDTH-1:0] DM_address,
    output logic [DATA_WIDTH-1:0] DM_in,
    input  logic [DATA_WIDTH-1:0] DM_out
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    // state  | meaning
    // IDLE   | arbitrate and issue reads, full writes, or the read half of an RMW
    // RMW_WR | write back the merged word; no grants this cycle
    typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

    state_t                state, state_nxt;
    logic                  sel;
    logic                  any_req;
    logic                  grant;
    logic                  rd_go;
    logic                  rmw_go;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [MASK_WIDTH-1:0] req_wstrb;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] merge_data_q;
    logic [ADDR_WIDTH-1:0] merge_addr_q;
    logic                  rvalid0_q, rvalid1_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
`ifndef DM_ARB_FIXED_PRIO_EN
    logic                  ptr;
`endif

    always_comb begin
        any_req = p0.req | p1.req;
`ifdef DM_ARB_FIXED_PRIO_EN
        sel = ~p0.req;
`else
        sel = (p0.req & p1.req) ? ptr : p1.req;
`endif
        req_write = sel ? p1.write : p0.write;
        req_addr  = sel ? p1.addr  : p0.addr;
        req_wdata = sel ? p1.wdata : p0.wdata;
        req_wstrb = sel ? p1.wstrb : p0.wstrb;
    end

    // Merge is taken straight from DM_out during the read half, so only the result is stored.
    always_comb begin
        merged = DM_out;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            if (req_wstrb[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
        end
    end

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        rd_go      = 1'b0;
        rmw_go     = 1'b0;
        DM_enable  = 1'b0;
        DM_write   = 1'b0;
        DM_address = '0;
        DM_in      = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant = 1'b1;
                        if (!req_write) begin
                            DM_enable  = 1'b1;
                            DM_address = req_addr;
                            rd_go      = 1'b1;
                        end else if (&req_wstrb) begin
                            DM_enable  = 1'b1;
                            DM_write   = 1'b1;
                            DM_address = req_addr;
                            DM_in      = req_wdata;
                        end else if (|req_wstrb) begin
                            DM_enable  = 1'b1;
                            DM_address = req_addr;
                            rmw_go     = 1'b1;
                            state_nxt  = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    DM_enable  = 1'b1;
                    DM_write   = 1'b1;
                    DM_address = merge_addr_q;
                    DM_in      = merge_data_q;
                    state_nxt  = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            merge_addr_q <= '0;
            merge_data_q <= '0;
        end else begin
            state     <= state_nxt;
            rvalid0_q <= rd_go & ~sel;
            rvalid1_q <= rd_go & sel;
            if (rd_go && !sel) rdata0_q <= DM_out;
            if (rd_go && sel)  rdata1_q <= DM_out;
            if (rmw_go) begin
                merge_addr_q <= req_addr;
                merge_data_q <= merged;
            end
        end
    end

`ifndef DM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        ptr <= 1'b0;
        else if (grant) ptr <= ~sel;
    end
`endif

    assign p0.gnt    = grant & ~sel;
    assign p1.gnt    = grant & sel;
    assign p0.rvalid = rvalid0_q;
    assign p1.rvalid = rvalid1_q;
    assign p0.rdata  = rdata0_q;
    assign p1.rdata  = rdata1_q;
    assign busy      = (state == RMW_WR) & ~rst;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: transaction-level memory model plus a behavioural DM.
module tb_dm_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy, DM_enable, DM_write;
    logic [15:0] DM_address;
    logic [31:0] DM_in, DM_out;

    dm_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) p0_if ();
    dm_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) p1_if ();

    dm_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if), .busy(busy),
        .DM_enable(DM_enable), .DM_write(DM_write), .DM_address(DM_address),
        .DM_in(DM_in), .DM_out(DM_out)
    );

    always #5 clk = ~clk;

    // Single-port DM: synchronous write, asynchronous read
    logic [31:0] dm_mem [0:65535];
    always @(posedge clk) if (DM_enable && DM_write) dm_mem[DM_address] <= DM_in;
    assign DM_out = dm_mem[DM_address];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // Reference model: word-level memory, pending RMW, last granted port
    logic [31:0] ref_mem [logic [15:0]];
    logic [31:0] q0[$], q1[$];
    int          log_port[$], log_cyc[$];
    int          last_port = 1;
    int          cyc = 0;
    int          busy_cycles = 0;
    bit          pend_v = 0;
    logic [15:0] pend_addr;
    logic [31:0] pend_data;
    logic [3:0]  pend_strb;
    logic [1:0]  rv_exp = 2'b00;
    logic [31:0] last_rmw_din = '0;

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = 0;
        for (int b = 0; b < 4; b++) begin
            logic [31:0] src;
            src = s[b] ? nw : old;
            r = r + (((src >> (8 * b)) % 256) << (8 * b));
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            pend_v    = 0;
            last_port = 1;
            rv_exp    = 2'b00;
            q0.delete();
            q1.delete();
        end else begin
            logic [1:0]  rv_nxt;
            int          w;
            bit          wr;
            logic [15:0] a;
            logic [31:0] d;
            logic [3:0]  s;
            cyc++;
            rv_nxt = 2'b00;
            check("rvalid", {62'b0, p1_if.rvalid, p0_if.rvalid}, {62'b0, rv_exp});
            if (p0_if.rvalid) begin
                if (q0.size() > 0) check("p0_rdata", p0_if.rdata, q0.pop_front());
                else check("p0_rvalid_unexpected", 1, 0);
            end
            if (p1_if.rvalid) begin
                if (q1.size() > 0) check("p1_rdata", p1_if.rdata, q1.pop_front());
                else check("p1_rvalid_unexpected", 1, 0);
            end
            check("busy", busy, pend_v);
            if (busy) busy_cycles++;
            if (pend_v) begin
                logic [31:0] m;
                m = byte_merge(ref_rd(pend_addr), pend_data, pend_strb);
                check("gnt_during_rmw", {p1_if.gnt, p0_if.gnt}, 0);
                check("rmw_dm_bus", {DM_enable, DM_write, DM_address, DM_in}, {1'b1, 1'b1, pend_addr, m});
                last_rmw_din = DM_in;
                ref_mem[pend_addr] = m;
                pend_v = 0;
            end else begin
                if (p0_if.req && p1_if.req) begin
`ifdef DM_ARB_FIXED_PRIO_EN
                    w = 0;
`else
                    w = (last_port == 0) ? 1 : 0;
`endif
                end else if (p0_if.req) w = 0;
                else if (p1_if.req) w = 1;
                else w = -1;
                check("gnt", {p1_if.gnt, p0_if.gnt}, (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00);
                if (w < 0) begin
                    check("idle_dm_bus", {DM_enable, DM_write, DM_address, DM_in}, 0);
                end else begin
                    wr = (w == 0) ? p0_if.write : p1_if.write;
                    a  = (w == 0) ? p0_if.addr  : p1_if.addr;
                    d  = (w == 0) ? p0_if.wdata : p1_if.wdata;
                    s  = (w == 0) ? p0_if.wstrb : p1_if.wstrb;
                    last_port = w;
                    log_port.push_back(w);
                    log_cyc.push_back(cyc);
                    if (!wr) begin
                        check("read_dm_bus", {DM_enable, DM_write, DM_address}, {1'b1, 1'b0, a});
                        if (w == 0) q0.push_back(ref_rd(a)); else q1.push_back(ref_rd(a));
                        rv_nxt[w] = 1'b1;
                    end else if (s == 4'hF) begin
                        check("full_write_dm_bus", {DM_enable, DM_write, DM_address, DM_in}, {1'b1, 1'b1, a, d});
                        ref_mem[a] = d;
                    end else if (s == 4'h0) begin
                        check("zero_strobe_dm_enable", DM_enable, 0);
                    end else begin
                        check("rmw_read_dm_bus", {DM_enable, DM_write, DM_address}, {1'b1, 1'b0, a});
                        pend_v = 1; pend_addr = a; pend_data = d; pend_strb = s;
                    end
                end
            end
            rv_exp = rv_nxt;
        end
    end

    task automatic drive(input int p, input bit rq, input bit wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (p == 0) begin
            p0_if.req = rq; p0_if.write = wr; p0_if.addr = a; p0_if.wdata = d; p0_if.wstrb = s;
        end else begin
            p1_if.req = rq; p1_if.write = wr; p1_if.addr = a; p1_if.wdata = d; p1_if.wstrb = s;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the grant
    task automatic issue(input int p, input bit wr, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int waited);
        bit got;
        got = 0;
        waited = 0;
        drive(p, 1, wr, a, d, s);
        while (!got && waited < 50) begin
            @(negedge clk);
            if ((p == 0) ? p0_if.gnt : p1_if.gnt) got = 1;
            else waited++;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL grant_timeout port=%0d actual=no_grant required=grant_within_50", p);
        end
        @(posedge clk); #1;
        drive(p, 0, 0, 0, 0, 0);
    endtask

    int wt, base;

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        #2;
        drive(0, 1, 0, 16'h0010, 0, 0);
        #1;
        check("reset_outputs", {p0_if.gnt, p1_if.gnt, p0_if.rvalid, p1_if.rvalid, busy, DM_enable, DM_write, DM_address}, 0);
        check("reset_rdata", {p0_if.rdata, p1_if.rdata}, 0);
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Plan 1: full write then read-back on port 0
        issue(0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, wt);
        check("t1_write_gnt_wait", wt, 0);
        issue(0, 0, 16'h0010, 0, 0, wt);
        check("t1_read_gnt_wait", wt, 0);
        @(negedge clk);
        check("t1_rdata", {p0_if.rvalid, p0_if.rdata}, {1'b1, 32'hDEADBEEF});
        @(posedge clk); #1;

        // Plan 2: partial-write merge on port 1
        issue(1, 1, 16'h0020, 32'h11223344, 4'hF, wt);
        base = busy_cycles;
        issue(1, 1, 16'h0020, 32'h0000AB00, 4'b0010, wt);
        @(posedge clk); #1;
        check("t2_busy_cycles", busy_cycles - base, 1);
        check("t2_rmw_dm_in", last_rmw_din, 32'h1122AB44);
        issue(1, 0, 16'h0020, 0, 0, wt);
        @(negedge clk);
        check("t2_readback", {p1_if.rvalid, p1_if.rdata}, {1'b1, 32'h1122AB44});
        @(posedge clk); #1;

        // Plan 3: both ports hold read requests
        base = log_port.size();
        fork
            begin for (int i = 0; i < 4; i++) begin int w0; issue(0, 0, 16'h0010, 0, 0, w0); end end
            begin for (int i = 0; i < 4; i++) begin int w1; issue(1, 0, 16'h0020, 0, 0, w1); end end
        join
        for (int i = 0; i < 4; i++) begin
`ifdef DM_ARB_FIXED_PRIO_EN
            check($sformatf("t3_grant_order_%0d", i), log_port[base + i], 0);
`else
            check($sformatf("t3_grant_order_%0d", i), log_port[base + i], i % 2);
`endif
        end
        @(posedge clk); #1;

        // Plan 4: p0 partial write contending with p1 read
        base = log_port.size();
        fork
            begin int w0; issue(0, 1, 16'h0010, 32'h5A000000, 4'b1000, w0); end
            begin int w1; issue(1, 0, 16'h0010, 0, 0, w1); end
        join
        check("t4_order", {log_port[base], log_port[base + 1]}, {32'd0, 32'd1});
        check("t4_p1_gnt_delay", log_cyc[base + 1] - log_cyc[base], 2);
        @(posedge clk); #1;

        // Plan 5: reset during the RMW write cycle
        issue(0, 1, 16'h0030, 32'hCAFEF00D, 4'hF, wt);
        issue(0, 1, 16'h0030, 32'h000000FF, 4'b0001, wt);
        rst = 1'b1;
        #1;
        check("t5_outputs_in_reset", {busy, DM_enable, DM_write, DM_address, DM_in}, 0);
        check("t5_rdata_in_reset", {p0_if.rdata, p1_if.rdata}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("t5_mem_unchanged", dm_mem[16'h0030], 32'hCAFEF00D);
        issue(0, 0, 16'h0030, 0, 0, wt);
        @(negedge clk);
        check("t5_readback", {p0_if.rvalid, p0_if.rdata}, {1'b1, 32'hCAFEF00D});
        @(posedge clk); #1;

        // Plan 6: zero-strobe write consumes one cycle
        base = log_port.size();
        issue(1, 1, 16'h0020, 32'hFFFFFFFF, 4'h0, wt);
        issue(0, 0, 16'h0020, 0, 0, wt);
        check("t6_next_grant", log_cyc[base + 1] - log_cyc[base], 1);
        check("t6_mem_unchanged", dm_mem[16'h0020], 32'h1122AB44);

        // Random traffic on a small address window
        for (int k = 0; k < 8; k++) issue(0, 1, 16'h0040 + 16'(k), $urandom, 4'hF, wt);
        fork
            for (int k = 0; k < 150; k++) begin
                int g0, w0; bit wr0; logic [3:0] s0;
                g0 = $urandom_range(0, 2);
                repeat (g0) begin @(posedge clk); #1; end
                wr0 = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0: s0 = 4'hF;
                    1: s0 = 4'h0;
                    default: s0 = 4'($urandom_range(1, 14));
                endcase
                issue(0, wr0, 16'h0040 + 16'($urandom_range(0, 7)), $urandom, s0, w0);
            end
            for (int k = 0; k < 150; k++) begin
                int g1, w1; bit wr1; logic [3:0] s1;
                g1 = $urandom_range(0, 2);
                repeat (g1) begin @(posedge clk); #1; end
                wr1 = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0: s1 = 4'hF;
                    1: s1 = 4'h0;
                    default: s1 = 4'($urandom_range(1, 14));
                endcase
                issue(1, wr1, 16'h0040 + 16'($urandom_range(0, 7)), $urandom, s1, w1);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
